// File: rtl/mv_xform_ctrl.sv
// Issue/flow controller for the pipelined 4x4 FP32 matrix-vector datapath:
// double-buffered matrix file, credit-throttled issue and a valid/ready result FIFO.
module mv_xform_ctrl #(
    parameter int IDW      = 8,
    parameter int PIPE_LAT = 5,
    parameter int OFD      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [3:0]                    cfg_addr,
    input  logic [31:0]                   cfg_wdata,
    input  logic                          cfg_commit,
    output logic                          cfg_busy,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IDW-1:0]                s_id,
    input  logic [127:0]                  s_vec,
    output logic [511:0]                  dp_mat,
    output logic                          dp_in_valid,
    output logic [IDW-1:0]                dp_in_id,
    output logic [127:0]                  dp_in_vec,
    input  logic                          dp_out_valid,
    input  logic [IDW-1:0]                dp_out_id,
    input  logic [127:0]                  dp_out_vec,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [IDW-1:0]                m_id,
    output logic [127:0]                  m_vec,
    output logic [$clog2(PIPE_LAT+2)-1:0] inflight,
    output logic                          err_ovf
);

    localparam int IFW = $clog2(PIPE_LAT + 2);
    localparam int CW  = $clog2(OFD + 1);
    localparam int PW  = (OFD > 1) ? $clog2(OFD) : 1;
    localparam int SW  = ((IFW > CW) ? IFW : CW) + 1;
    localparam int EW  = IDW + 128;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    function automatic logic [511:0] ident_mat();
        logic [511:0] m;
        m = {512{1'b0}};
        for (int i = 0; i < 4; i++) begin
            m[32*(i*5) +: 32] = 32'h3F80_0000;
        end
        return m;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OFD - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    localparam logic [511:0] IDENT_MAT = ident_mat();

    state_t          state_r, state_nxt_s;
    logic [511:0]    shadow_r, active_r;
    logic [IFW-1:0]  inflight_r;
    logic [EW-1:0]   mem_r [OFD];
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r, rd_nxt_s;
    logic [CW-1:0]   count_r, count_nxt_s, remain_s;
    logic [IDW-1:0]  m_id_r;
    logic [127:0]    m_vec_r;
    logic            err_ovf_r;
    logic [SW-1:0]   occ_s;
    logic            s_ready_s, cfg_busy_s, swap_s;
    logic            issue_s, pop_s, full_s, wr_en_s, ovf_s, head_load_s;
    logic [EW-1:0]   head_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a commit drains the pipe before the one-cycle matrix swap
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN:   state_nxt_s = cfg_commit ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = (inflight_r == {IFW{1'b0}}) ? ST_SWAP : ST_DRAIN;
            ST_SWAP:  state_nxt_s = ST_RUN;
            default:  state_nxt_s = ST_RUN;
        endcase
    end

    assign occ_s = SW'(inflight_r) + SW'(count_r);

    // FSM outputs: issue only in RUN and only while every in-flight result has a FIFO slot
    always_comb begin
        s_ready_s  = 1'b0;
        cfg_busy_s = 1'b0;
        swap_s     = 1'b0;
        case (state_r)
            ST_RUN:   s_ready_s = !rst && (occ_s < SW'(OFD));
            ST_DRAIN: cfg_busy_s = 1'b1;
            ST_SWAP: begin
                cfg_busy_s = 1'b1;
                swap_s     = 1'b1;
            end
            default:  s_ready_s = 1'b0;
        endcase
    end

    assign issue_s = s_valid && s_ready_s;

    // Matrix register files; the swap copies the shadow as it was before any same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= IDENT_MAT;
            active_r <= IDENT_MAT;
        end else begin
            if (cfg_we) begin
                shadow_r[32*cfg_addr +: 32] <= cfg_wdata;
            end
            if (swap_s) begin
                active_r <= shadow_r;
            end
        end
    end

    // In-flight credit counter, saturating at zero on a spurious return
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= {IFW{1'b0}};
        end else begin
            case ({issue_s, dp_out_valid})
                2'b10:   inflight_r <= inflight_r + IFW'(1);
                2'b01:   inflight_r <= (inflight_r == {IFW{1'b0}}) ? inflight_r : inflight_r - IFW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign pop_s   = (count_r != {CW{1'b0}}) && m_ready;
    assign full_s  = (count_r == CW'(OFD));
    assign wr_en_s = dp_out_valid && (!full_s || pop_s);
    assign ovf_s   = dp_out_valid && full_s && !pop_s;

    // FIFO pointer/count next values and the head entry that m_id/m_vec will hold next cycle
    always_comb begin
        rd_nxt_s    = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
        remain_s    = count_r - CW'(pop_s);
        head_s      = mem_r[rd_nxt_s];
        head_load_s = 1'b1;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (remain_s == {CW{1'b0}}) begin
            head_s      = {dp_out_id, dp_out_vec};
            head_load_s = wr_en_s;
        end else begin
            head_load_s = 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {dp_out_id, dp_out_vec};
        end
    end

    // FIFO control, registered head and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r  <= {PW{1'b0}};
            wr_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            m_id_r    <= {IDW{1'b0}};
            m_vec_r   <= {128{1'b0}};
            err_ovf_r <= 1'b0;
        end else begin
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (head_load_s) begin
                {m_id_r, m_vec_r} <= head_s;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
        end
    end

    assign cfg_busy    = cfg_busy_s;
    assign s_ready     = s_ready_s;
    assign dp_mat      = active_r;
    assign dp_in_valid = issue_s;
    assign dp_in_id    = s_id;
    assign dp_in_vec   = s_vec;
    assign m_valid     = (count_r != {CW{1'b0}});
    assign m_id        = m_id_r;
    assign m_vec       = m_vec_r;
    assign inflight    = inflight_r;
    assign err_ovf     = err_ovf_r;

endmodule

// File: tb/tb_mv_xform_ctrl.sv
// Scoreboard bench for mv_xform_ctrl with a behavioural fixed-latency datapath
// and a matrix-math reference model.
module tb_mv_xform_ctrl;

    localparam int IDW = 8;
    localparam int PL  = 5;
    localparam int OFD = 8;

    logic clk = 1'b0;
    logic rst, cfg_we, cfg_commit, s_valid, m_ready;
    logic [3:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic [IDW-1:0] s_id, dp_in_id, dp_out_id, m_id;
    logic [127:0] s_vec, dp_in_vec, dp_out_vec, m_vec;
    logic [511:0] dp_mat;
    logic cfg_busy, s_ready, dp_in_valid, dp_out_valid, m_valid, err_ovf;
    logic [$clog2(PL+2)-1:0] inflight;

    mv_xform_ctrl #(.IDW(IDW), .PIPE_LAT(PL), .OFD(OFD)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .s_valid(s_valid), .s_ready(s_ready),
        .s_id(s_id), .s_vec(s_vec), .dp_mat(dp_mat), .dp_in_valid(dp_in_valid),
        .dp_in_id(dp_in_id), .dp_in_vec(dp_in_vec), .dp_out_valid(dp_out_valid),
        .dp_out_id(dp_out_id), .dp_out_vec(dp_out_vec), .m_valid(m_valid), .m_ready(m_ready),
        .m_id(m_id), .m_vec(m_vec), .inflight(inflight), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // FP32 <-> real for zero and normal numbers (all values used here are small integers)
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:0] == 31'd0) d = {b[31], 63'd0};
        else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        d = $realtobits(x);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [127:0] rand_vec();
        logic [127:0] v;
        for (int c = 0; c < 4; c++) v[32*c +: 32] = r2f(real'(int'($urandom_range(16)) - 8));
        return v;
    endfunction

    // Behavioural datapath: fixed latency PL, computes mat * vec from the bits it is given
    logic pv [PL];
    logic [IDW-1:0] pid [PL];
    logic [127:0] pvec [PL];

    function automatic logic [127:0] dp_mv(input logic [511:0] m, input logic [127:0] v);
        logic [127:0] o;
        real acc;
        for (int r = 0; r < 4; r++) begin
            acc = 0.0;
            for (int c = 0; c < 4; c++) acc = acc + f2r(m[32*(r*4+c) +: 32]) * f2r(v[32*c +: 32]);
            o[32*r +: 32] = r2f(acc);
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PL; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= dp_in_valid;
            pid[0] <= dp_in_id;
            pvec[0] <= dp_mv(dp_mat, dp_in_vec);
            for (int i = 1; i < PL; i++) begin
                pv[i] <= pv[i-1];
                pid[i] <= pid[i-1];
                pvec[i] <= pvec[i-1];
            end
        end
    end
    assign dp_out_valid = pv[PL-1];
    assign dp_out_id = pid[PL-1];
    assign dp_out_vec = pvec[PL-1];

    // Reference model: matrices as reals, occupancy as counts, commit phase as RUN/DRAIN/SWAP
    real ref_act [16];
    real ref_sh [16];
    int ph, ref_inf, ref_cnt;
    logic [IDW+127:0] q [$];

    function automatic logic [127:0] ref_mv(input logic [127:0] v);
        logic [127:0] o;
        real acc;
        for (int r = 0; r < 4; r++) begin
            acc = 0.0;
            for (int c = 0; c < 4; c++) acc = acc + ref_act[r*4+c] * f2r(v[32*c +: 32]);
            o[32*r +: 32] = r2f(acc);
        end
        return o;
    endfunction

    always @(negedge clk) begin
        logic exp_rdy, issue, pop, push_ok;
        if (rst) begin
            chk("s_ready_in_rst", s_ready, 1'b0);
            ph = 0; ref_inf = 0; ref_cnt = 0;
            q.delete();
            for (int i = 0; i < 16; i++) begin
                ref_act[i] = (i % 5 == 0) ? 1.0 : 0.0;
                ref_sh[i] = ref_act[i];
            end
        end else begin
            exp_rdy = (ph == 0) && (ref_inf + ref_cnt < OFD);
            chk("s_ready", s_ready, exp_rdy);
            chk("cfg_busy", cfg_busy, ph != 0);
            chk("inflight", inflight, ref_inf);
            chk("m_valid", m_valid, ref_cnt != 0);
            chk("err_ovf", err_ovf, 1'b0);
            issue = s_valid && exp_rdy;
            if (issue) q.push_back({s_id, ref_mv(s_vec)});
            pop = (ref_cnt != 0) && m_ready;
            push_ok = dp_out_valid && !(ref_cnt == OFD && !pop);
            if (ph == 0 && cfg_commit) ph = 1;
            else if (ph == 1 && ref_inf == 0) ph = 2;
            else if (ph == 2) begin
                for (int i = 0; i < 16; i++) ref_act[i] = ref_sh[i];
                ph = 0;
            end
            if (cfg_we) ref_sh[cfg_addr] = f2r(cfg_wdata);
            ref_cnt = ref_cnt + int'(push_ok) - int'(pop);
            if (issue && !dp_out_valid) ref_inf++;
            else if (!issue && dp_out_valid && ref_inf > 0) ref_inf--;
        end
    end

    // Monitor: every presented output must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL m_unexpected: got id %0h, want no output", m_id);
            end else begin
                chk("m_id", m_id, q[0][IDW+127:128]);
                chk("m_vec", m_vec, q[0][127:0]);
                if (m_ready) void'(q.pop_front());
            end
        end
    end

    logic [511:0] ident;
    logic [IDW-1:0] next_id = 8'h20;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int acc, acc2, nv, first, last, hs;
        ident = {512{1'b0}};
        for (int i = 0; i < 4; i++) ident[32*(i*5) +: 32] = 32'h3F80_0000;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 32'd0; cfg_commit = 1'b0;
        s_valid = 1'b0; s_id = 8'h00; s_vec = 128'd0; m_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m_id", m_id, 8'h00);
        chk("rst_m_vec", m_vec, 128'd0);
        chk("rst_dp_mat", dp_mat, ident);
        tick();

        // 1: single vertex latency through identity
        hs = -1; first = -1;
        for (int k = 0; k < 20; k++) begin
            s_valid = (k == 0); s_id = 8'h11;
            s_vec = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
            @(negedge clk);
            if (s_valid && s_ready) hs = k;
            if (m_valid && first < 0) begin
                first = k;
                chk("t1_m_id", m_id, 8'h11);
                chk("t1_m_vec", m_vec, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
            end
            tick();
        end
        s_valid = 1'b0;
        chk("t1_latency", first - hs, 6);

        // 2: 16 back-to-back with m_ready=1
        nv = 0; first = -1; last = -1;
        for (int k = 0; k < 40; k++) begin
            s_valid = (k < 16); s_id = next_id; s_vec = rand_vec();
            @(negedge clk);
            if (s_valid && s_ready) next_id++;
            if (m_valid) begin
                nv++; last = k;
                if (first < 0) first = k;
            end
            tick();
        end
        s_valid = 1'b0;
        chk("t2_out_count", nv, 16);
        chk("t2_out_span", last - first, 15);

        // 3: backpressure fills exactly OFD credits, then drains in order
        m_ready = 1'b0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1; s_id = next_id; s_vec = rand_vec();
            @(negedge clk);
            if (s_ready) begin acc++; next_id++; end
            tick();
        end
        chk("t3_accepted", acc, 8);
        m_ready = 1'b1; acc2 = 0;
        for (int k = 0; k < 30; k++) begin
            s_valid = (k < 10); s_id = next_id; s_vec = rand_vec();
            @(negedge clk);
            if (s_valid && s_ready) begin acc2++; next_id++; end
            tick();
        end
        chk("t3_resumed", acc2 > 0, 1'b1);

        // 4: diag 2.0 into shadow, commit with 3 in flight
        for (int i = 0; i < 16; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = (i % 5 == 0) ? 32'h4000_0000 : 32'h0;
            tick();
        end
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_id = next_id; next_id++; s_vec = rand_vec();
            tick();
        end
        s_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        acc = 0;
        @(negedge clk);
        chk("t4_busy", cfg_busy, 1'b1);
        while (cfg_busy && acc < 30) begin
            tick(); @(negedge clk); acc++;
        end
        chk("t4_busy_bounded", acc < 30, 1'b1);
        chk("t4_dp_mat_m00", dp_mat[31:0], 32'h4000_0000);
        tick();
        s_valid = 1'b1; s_id = 8'h44; s_vec = {4{32'h3F80_0000}};
        tick();
        idle(12);

        // 5: write in the SWAP cycle stays in shadow; commit during DRAIN ignored
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h4040_0000;
        tick();
        cfg_we = 1'b0; cfg_commit = 1'b1;
        tick();
        tick();
        cfg_commit = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h40A0_0000;
        tick();
        cfg_we = 1'b0;
        idle(3);
        @(negedge clk);
        chk("t5_m00_old", dp_mat[31:0], 32'h4040_0000);
        chk("t5_not_busy", cfg_busy, 1'b0);
        tick();
        cfg_commit = 1'b1;
        tick();
        idle(4);
        @(negedge clk);
        chk("t5_m00_new", dp_mat[31:0], 32'h40A0_0000);
        tick();
        s_valid = 1'b1; s_id = 8'h55; s_vec = {4{32'h3F80_0000}};
        tick();
        idle(12);

        // 6: reset with 4 in flight and 2 in the FIFO
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s_valid = (k < 6); s_id = next_id; s_vec = rand_vec();
            rst = (k == 7);
            if (s_valid) next_id++;
            @(negedge clk);
            if (k == 7) chk("t6_inflight_pre", inflight, 4);
            if (k == 8) begin
                chk("t6_m_valid", m_valid, 1'b0);
                chk("t6_inflight", inflight, 0);
                chk("t6_dp_mat", dp_mat, ident);
            end
            tick();
        end
        m_ready = 1'b1;
        idle(15);

        // Random traffic with occasional shadow writes and commits
        for (int k = 0; k < 500; k++) begin
            s_valid = ($urandom_range(3) != 0);
            s_id = 8'($urandom); s_vec = rand_vec();
            m_ready = ($urandom_range(9) < 7);
            cfg_we = ($urandom_range(7) == 0);
            cfg_addr = 4'($urandom_range(15));
            cfg_wdata = r2f(real'(int'($urandom_range(6)) - 3));
            cfg_commit = ($urandom_range(29) == 0);
            tick();
        end
        m_ready = 1'b1;
        idle(30);
        chk("final_queue_empty", q.size(), 0);
        chk("final_err_ovf", err_ovf, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
